nios2_debug_scan_master: RTL and testbench
==========================================

Name: nios2_debug_scan_master

Overview:
- Host-side initiator for the Nios II debug slave's virtual-JTAG interface.
- Converts one scan command (IR value plus DR_WIDTH payload) into a cycle-accurate UIR/CDR/SDR/UDR sequence on the vji_* signals, and returns the captured DR.
- Used in simulation benches and on-chip self-test in place of the sld_virtual_jtag_basic hub, driving the debug slave's TCK-domain logic directly.

Parameters:
- DR_WIDTH, 38, shift length of the data register (matches jdo/sr width).
- IR_WIDTH, 2, width of vji_ir_in / vji_ir_out.
- TCK_DIV, 2, clk cycles per tck half-period (≥1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  scan request.
- cmd_ready  out  1  high when idle and able to accept.
- cmd_ir  in  IR_WIDTH  instruction to present on vji_ir_in.
- cmd_dr  in  DR_WIDTH  data to shift out, LSB first.
- rsp_valid  out  1  one-clk pulse when the scan completes.
- rsp_dr  out  DR_WIDTH  captured tdo bits, held until the next completion.
- rsp_ir  out  IR_WIDTH  vji_ir_out sampled during UIR.
- vji_tck  out  1  generated scan clock.
- vji_tdi  out  1  serial data to the slave.
- vji_tdo  in  1  serial data from the slave.
- vji_ir_in  out  IR_WIDTH  instruction to the slave.
- vji_ir_out  in  IR_WIDTH  slave status.
- vji_uir / vji_cdr / vji_sdr / vji_udr  out  1 each  virtual state strobes.
- vji_rti  out  1  run-test-idle indicator.

Behaviour:
- Clock and reset: one clock, clk; reset_n is asynchronous, active-low.
- Reset values: vji_tck=0, vji_tdi=0, all strobes=0, vji_rti=1, vji_ir_in=0, rsp_valid=0, rsp_dr=0, rsp_ir=0, cmd_ready=1.
- Tick generation: half-period counter 0..TCK_DIV-1, running only outside IDLE. The terminal count is a "tick"; each tick toggles vji_tck. A rising tick takes tck 0->1; a falling tick takes tck 1->0.
- FSM states: IDLE, UIR, CDR, SDR, UDR. All state changes occur on falling ticks, except IDLE->UIR.
- IDLE: cmd_ready=1, vji_rti=1.
  - cmd_valid&cmd_ready loads ir/dr registers, clears the half-period counter and bit counter, sets vji_ir_in=cmd_ir and vji_rti=0, and enters UIR with tck=0.
- UIR: vji_uir=1 for one tck period. rsp_ir latches vji_ir_out on the rising tick. Falling tick -> CDR.
- CDR: vji_cdr=1 for one tck period. Falling tick -> SDR, with vji_tdi=sh[0].
- SDR: vji_sdr=1.
  - Each rising tick: sh <= {vji_tdo, sh[DR_WIDTH-1:1]}; bitcnt++.
  - Each falling tick: if bitcnt==DR_WIDTH go to UDR; else vji_tdi=sh[0].
  - Exactly DR_WIDTH rising edges occur in SDR.
- UDR: vji_udr=1 for one tck period. Falling tick -> IDLE; rsp_dr<=sh; rsp_valid pulses for 1 clk; vji_tdi=0; vji_rti=1.
- Latency: cmd accept -> rsp_valid = (DR_WIDTH+3)*2*TCK_DIV clks. Defaults give 164.
- Only one strobe is high at any time. Strobes and vji_tdi change only coincident with falling edges of tck, and are stable across rising edges.
- cmd_valid while busy is ignored (cmd_ready=0).
- A new cmd may be accepted in the same clk that rsp_valid pulses (state is IDLE in that cycle).
- vji_ir_in holds its last value in IDLE.
- Reset asserted mid-scan aborts immediately to reset values; no rsp_valid is produced.
- TCK_DIV=1: tck toggles every clk.

Optional Feature:
- Macro NIOS2_DBG_IR_SKIP_EN.
- Defined: if cmd_ir equals the vji_ir_in value already held from a prior completed scan (flag valid since reset), UIR is skipped and IDLE->CDR directly. Latency drops by 2*TCK_DIV, and rsp_ir is the previously captured value.
- Undefined: UIR is always issued.

Decomposition:
- Package nios2_debug_pkg holds:
  - state enum (IDLE, UIR, CDR, SDR, UDR);
  - DR_WIDTH_DEFAULT=38 and IR_WIDTH_DEFAULT=2;
  - IR code constants (MONITOR=0, BREAK=1, TRACE=2, RESERVED=3).
- One natural sub-module, nios2_debug_tck_gen: half-period counter, tck register, rise/fall tick pulses, enable input.

Test Plan:
- Loopback (vji_tdo tied to vji_tdi), cmd_ir=2'b01, cmd_dr=38'h2A_5A5A_A5A5 -> rsp_dr=38'h2A_5A5A_A5A5; rsp_valid exactly 164 clks after accept; uir/cdr/udr each high 4 clks; sdr high 152 clks.
- vji_tdo held 1, any cmd_dr -> rsp_dr=38'h3F_FFFF_FFFF; vji_tdi sequence observed on tck rising edges equals cmd_dr LSB first.
- vji_ir_out=2'b10 during UIR -> rsp_ir=2'b10; vji_ir_in=cmd_ir from UIR onward; vji_rti low from accept until UDR exit.
- Back-to-back: cmd_valid held high with two commands -> second accepted on the rsp_valid cycle; cmd_valid mid-scan is ignored.
- Reset pulse at bit 17 of SDR -> all outputs return to reset values asynchronously; no rsp_valid; next cmd completes normally.
- With NIOS2_DBG_IR_SKIP_EN defined, two scans with the same cmd_ir -> the second shows no vji_uir and completes in 160 clks.

Source files
------------

// File: rtl/nios2_debug_pkg.sv
// ---------------------------------------------------------------------------
// nios2_debug_pkg
// Shared types and constants for the Nios II debug scan master.
//   scan_state_t      : virtual-JTAG sequencing states.
//   DR_WIDTH_DEFAULT  : debug slave data-register length (jdo/sr width).
//   IR_WIDTH_DEFAULT  : width of the virtual instruction register.
//   IR_* constants    : instruction codes understood by the debug slave.
// ---------------------------------------------------------------------------
package nios2_debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SDR,
    ST_UDR
  } scan_state_t;

  localparam int DR_WIDTH_DEFAULT = 38;
  localparam int IR_WIDTH_DEFAULT = 2;

  localparam logic [1:0] IR_MONITOR  = 2'd0;
  localparam logic [1:0] IR_BREAK    = 2'd1;
  localparam logic [1:0] IR_TRACE    = 2'd2;
  localparam logic [1:0] IR_RESERVED = 2'd3;

endpackage

// File: rtl/nios2_debug_scan_master_if.sv
// ---------------------------------------------------------------------------
// nios2_debug_scan_master_if
// Command/response channel of the debug scan master.
//   cmd_valid/cmd_ready : request handshake, cmd_ir + cmd_dr payload.
//   rsp_valid           : one-clk completion pulse, rsp_dr/rsp_ir held after.
// Modports: master = requester (host/bench), slave = scan master.
// ---------------------------------------------------------------------------
interface nios2_debug_scan_master_if
  import nios2_debug_pkg::*;
#(
  parameter int DR_WIDTH = DR_WIDTH_DEFAULT,
  parameter int IR_WIDTH = IR_WIDTH_DEFAULT
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [DR_WIDTH-1:0] cmd_dr;
  logic                rsp_valid;
  logic [DR_WIDTH-1:0] rsp_dr;
  logic [IR_WIDTH-1:0] rsp_ir;

  modport master (
    output cmd_valid, cmd_ir, cmd_dr,
    input  cmd_ready, rsp_valid, rsp_dr, rsp_ir
  );

  modport slave (
    input  cmd_valid, cmd_ir, cmd_dr,
    output cmd_ready, rsp_valid, rsp_dr, rsp_ir
  );
endinterface

// File: rtl/nios2_debug_tck_gen.sv
// ---------------------------------------------------------------------------
// nios2_debug_tck_gen
// Scan-clock generator. A half-period counter runs 0..TCK_DIV-1 while en is
// high; its terminal count is a tick that toggles tck.
//   clk, reset_n : system clock, asynchronous active-low reset.
//   en           : run the counter (scan in progress).
//   clr          : restart counter with tck low (start of a scan).
//   tck          : generated scan clock (registered).
//   rise, fall   : combinational pulses in the clk cycle whose edge takes
//                  tck 0->1 (rise) or 1->0 (fall).
// ---------------------------------------------------------------------------
module nios2_debug_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tck,
  output logic rise,
  output logic fall
);
  // Keep at least one counter bit so TCK_DIV=1 still elaborates.
  localparam int CNT_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TCK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             tick;

  assign tick = en && !clr && (cnt == LAST);
  assign rise = tick && !tck;
  assign fall = tick && tck;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (en) begin
      if (cnt == LAST) begin
        cnt <= '0;
        tck <= ~tck;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/nios2_debug_scan_master.sv
// ---------------------------------------------------------------------------
// nios2_debug_scan_master
// Host-side virtual-JTAG initiator for the Nios II debug slave. Turns one
// command (IR + DR payload) into a UIR/CDR/SDR/UDR strobe sequence clocked by
// a generated vji_tck, shifting cmd_dr out LSB first and capturing vji_tdo.
// Ports:
//   clk, reset_n           : system clock, asynchronous active-low reset.
//   bus (slave modport)    : cmd_valid/ready/ir/dr in, rsp_valid/dr/ir out.
//   vji_tck, vji_tdi       : scan clock and serial data to the slave.
//   vji_tdo                : serial data from the slave.
//   vji_ir_in / vji_ir_out : instruction to / status from the slave.
//   vji_uir/cdr/sdr/udr    : one-hot virtual state strobes.
//   vji_rti                : high while idle.
// Build option: NIOS2_DBG_IR_SKIP_EN skips UIR when the requested IR equals
// the IR already installed by a previously completed scan.
// ---------------------------------------------------------------------------
module nios2_debug_scan_master
  import nios2_debug_pkg::*;
#(
  parameter int DR_WIDTH = DR_WIDTH_DEFAULT,
  parameter int IR_WIDTH = IR_WIDTH_DEFAULT,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  nios2_debug_scan_master_if.slave bus,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);
  localparam int BIT_W = $clog2(DR_WIDTH + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DR_WIDTH);

  scan_state_t         state;
  logic [DR_WIDTH-1:0] sh;
  logic [BIT_W-1:0]    bitcnt;
  logic                accept;
  logic                skip_uir;
  logic                tck_en;
  logic                tck_rise;
  logic                tck_fall;

  assign accept = (state == ST_IDLE) && bus.cmd_valid;
  assign tck_en = (state != ST_IDLE);

  nios2_debug_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (tck_en),
    .clr     (accept),
    .tck     (vji_tck),
    .rise    (tck_rise),
    .fall    (tck_fall)
  );

`ifdef NIOS2_DBG_IR_SKIP_EN
  // vji_ir_in only counts as installed once a scan has completed with it.
  logic ir_seen;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_seen <= 1'b0;
    end else if (state == ST_UDR && tck_fall) begin
      ir_seen <= 1'b1;
    end
  end

  assign skip_uir = ir_seen && (bus.cmd_ir == vji_ir_in);
`else
  assign skip_uir = 1'b0;
`endif

  // Shift register is pure data: loaded on accept, shifted on rising ticks.
  always_ff @(posedge clk) begin
    if (accept) begin
      sh <= bus.cmd_dr;
    end else if (state == ST_SDR && tck_rise) begin
      sh <= {vji_tdo, sh[DR_WIDTH-1:1]};
    end
  end

  // Sequencer: every transition except the start of a scan is taken on a
  // falling tick, so strobes and tdi only move with tck 1->0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      bitcnt        <= '0;
      vji_tdi       <= 1'b0;
      vji_uir       <= 1'b0;
      vji_cdr       <= 1'b0;
      vji_sdr       <= 1'b0;
      vji_udr       <= 1'b0;
      vji_rti       <= 1'b1;
      vji_ir_in     <= '0;
      bus.cmd_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_dr    <= '0;
      bus.rsp_ir    <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            vji_ir_in     <= bus.cmd_ir;
            vji_rti       <= 1'b0;
            bus.cmd_ready <= 1'b0;
            bitcnt        <= '0;
            if (skip_uir) begin
              state   <= ST_CDR;
              vji_cdr <= 1'b1;
            end else begin
              state   <= ST_UIR;
              vji_uir <= 1'b1;
            end
          end
        end
        ST_UIR: begin
          if (tck_rise) begin
            bus.rsp_ir <= vji_ir_out;
          end
          if (tck_fall) begin
            state   <= ST_CDR;
            vji_uir <= 1'b0;
            vji_cdr <= 1'b1;
          end
        end
        ST_CDR: begin
          if (tck_fall) begin
            state   <= ST_SDR;
            vji_cdr <= 1'b0;
            vji_sdr <= 1'b1;
            vji_tdi <= sh[0];
          end
        end
        ST_SDR: begin
          if (tck_rise) begin
            bitcnt <= bitcnt + 1'b1;
          end
          if (tck_fall) begin
            if (bitcnt == LAST_BIT) begin
              state   <= ST_UDR;
              vji_sdr <= 1'b0;
              vji_udr <= 1'b1;
            end else begin
              vji_tdi <= sh[0];
            end
          end
        end
        ST_UDR: begin
          if (tck_fall) begin
            state         <= ST_IDLE;
            vji_udr       <= 1'b0;
            vji_tdi       <= 1'b0;
            vji_rti       <= 1'b1;
            bus.cmd_ready <= 1'b1;
            bus.rsp_dr    <= sh;
            bus.rsp_valid <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nios2_debug_scan_master.sv
// ---------------------------------------------------------------------------
// tb_nios2_debug_scan_master
// Self-checking bench for nios2_debug_scan_master (default parameters).
// Each accepted command pushes its expected response onto a queue; a monitor
// pops and compares on rsp_valid, and tracks strobe/rti/ir invariants.
// Honors NIOS2_DBG_IR_SKIP_EN for the IR-skip scenario.
// ---------------------------------------------------------------------------
module tb_nios2_debug_scan_master;
  localparam int DRW = 38;
  localparam int IRW = 2;
  localparam int LAT_FULL = 164;
  localparam int LAT_SKIP = 160;

  logic           clk;
  logic           reset_n;
  logic           vji_tck, vji_tdi, vji_tdo;
  logic [IRW-1:0] vji_ir_in, vji_ir_out;
  logic           vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

  int tdo_mode;  // 0 loopback, 1 constant one, 2 constant zero
  assign vji_tdo = (tdo_mode == 0) ? vji_tdi : (tdo_mode == 1);

  nios2_debug_scan_master_if #(.DR_WIDTH(DRW), .IR_WIDTH(IRW)) bus ();

  nios2_debug_scan_master #(.DR_WIDTH(DRW), .IR_WIDTH(IRW), .TCK_DIV(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .vji_tck    (vji_tck),
    .vji_tdi    (vji_tdi),
    .vji_tdo    (vji_tdo),
    .vji_ir_in  (vji_ir_in),
    .vji_ir_out (vji_ir_out),
    .vji_uir    (vji_uir),
    .vji_cdr    (vji_cdr),
    .vji_sdr    (vji_sdr),
    .vji_udr    (vji_udr),
    .vji_rti    (vji_rti)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [DRW-1:0] dr;
    logic [DRW-1:0] exp_dr;
    logic [IRW-1:0] ir;
    logic [IRW-1:0] exp_rir;
    int             exp_lat;
    int             exp_uir;
    longint         acc;
  } sb_t;

  typedef struct {
    logic [IRW-1:0] ir;
    logic [DRW-1:0] dr;
    int             mode;
    logic [IRW-1:0] ir_out;
    logic [DRW-1:0] exp_dr;
    logic [IRW-1:0] exp_rir;
  } vec_t;

  sb_t    sb[$];
  int     checks = 0;
  int     errors = 0;
  int     inv_err = 0;
  int     rsp_cnt = 0;
  longint cyc = 0;
  logic [DRW-1:0] tdi_seq = '0;

  always @(posedge clk) cyc++;

  // tdi as seen by the slave on each tck rising edge inside SDR.
  always @(posedge vji_tck) if (vji_sdr) tdi_seq = {vji_tdi, tdi_seq[DRW-1:1]};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int       n_uir, n_cdr, n_sdr, n_udr;
  bit       busy = 0;
  logic [IRW-1:0] cur_ir = '0;
  logic [3:0] prev_strb = '0;
  logic       prev_tck = 1'b0, prev_tdi = 1'b0;

  always @(negedge clk) begin
    logic [3:0] strb;
    sb_t e;
    if (!reset_n) begin
      busy = 0;
      prev_strb = '0;
      prev_tck = 1'b0;
      prev_tdi = 1'b0;
    end else begin
      strb = {vji_uir, vji_cdr, vji_sdr, vji_udr};
      if ($countones(strb) > 1) inv_err++;
      if ((strb != prev_strb || vji_tdi != prev_tdi) && prev_strb != '0 &&
          !(prev_tck && !vji_tck)) inv_err++;
      if (bus.rsp_valid) begin
        busy = 0;
        rsp_cnt++;
        if (sb.size() == 0) begin
          chk("spurious_rsp", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("rsp_dr", e.exp_dr == bus.rsp_dr ? 64'(bus.rsp_dr) : 64'(bus.rsp_dr), e.exp_dr);
          chk("rsp_ir", bus.rsp_ir, e.exp_rir);
          chk("latency", cyc - e.acc, e.exp_lat);
          chk("uir_clks", n_uir, e.exp_uir);
          chk("cdr_clks", n_cdr, 4);
          chk("sdr_clks", n_sdr, 152);
          chk("udr_clks", n_udr, 4);
          chk("tdi_seq", tdi_seq, e.dr);
          chk("ir_in", vji_ir_in, e.ir);
        end
      end
      if (vji_rti !== !busy || bus.cmd_ready !== !busy) inv_err++;
      if (busy && vji_ir_in !== cur_ir) inv_err++;
      if (bus.cmd_valid && bus.cmd_ready) begin
        busy = 1;
        cur_ir = bus.cmd_ir;
        n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0;
      end
      n_uir += int'(vji_uir);
      n_cdr += int'(vji_cdr);
      n_sdr += int'(vji_sdr);
      n_udr += int'(vji_udr);
      prev_strb = strb;
      prev_tck = vji_tck;
      prev_tdi = vji_tdi;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_ready(output bit ok);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cmd_ready && n < 1000);
    ok = bus.cmd_ready;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic push(input logic [IRW-1:0] ir, input logic [DRW-1:0] dr,
                      input logic [DRW-1:0] exp_dr, input logic [IRW-1:0] exp_rir,
                      input int exp_lat, input int exp_uir);
    sb_t e;
    e.dr = dr; e.exp_dr = exp_dr; e.ir = ir; e.exp_rir = exp_rir;
    e.exp_lat = exp_lat; e.exp_uir = exp_uir;
    e.acc = cyc + 1;  // the command is taken on the next rising clk edge
    sb.push_back(e);
  endtask

  task automatic send(input logic [IRW-1:0] ir, input logic [DRW-1:0] dr,
                      input logic [DRW-1:0] exp_dr, input logic [IRW-1:0] exp_rir,
                      input int exp_lat, input int exp_uir, input bit hold);
    bit ok;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_ir = ir;
    bus.cmd_dr = dr;
    wait_ready(ok);
    if (ok) push(ir, dr, exp_dr, exp_rir, exp_lat, exp_uir);
    if (!hold) begin
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("rsp_timeout", sb.size(), 0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_tck"}, vji_tck, 0);
    chk({tag, "_tdi"}, vji_tdi, 0);
    chk({tag, "_strobes"}, {vji_uir, vji_cdr, vji_sdr, vji_udr}, 0);
    chk({tag, "_rti"}, vji_rti, 1);
    chk({tag, "_ir_in"}, vji_ir_in, 0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_dr"}, bus.rsp_dr, 0);
    chk({tag, "_rsp_ir"}, bus.rsp_ir, 0);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
  endtask

  // ---------------- stimulus ----------------
  vec_t vecs[5];

  initial begin : main
    bit ok;
    int n;
    int rsp_before;

    vecs[0] = '{2'b01, 38'h2A_5A5A_A5A5, 0, 2'b00, 38'h2A_5A5A_A5A5, 2'b00};
    vecs[1] = '{2'b10, 38'h15_A5A5_5A5A, 1, 2'b10, 38'h3F_FFFF_FFFF, 2'b10};
    vecs[2] = '{2'b11, 38'h00_0000_0001, 2, 2'b01, 38'h00_0000_0000, 2'b01};
    vecs[3] = '{2'b00, 38'h3F_FFFF_FFFF, 0, 2'b11, 38'h3F_FFFF_FFFF, 2'b11};
    vecs[4] = '{2'b01, 38'h12_3456_789A, 0, 2'b10, 38'h12_3456_789A, 2'b10};

    reset_n = 1'b0;
    tdo_mode = 0;
    vji_ir_out = '0;
    bus.cmd_valid = 1'b0;
    bus.cmd_ir = '0;
    bus.cmd_dr = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      tdo_mode = vecs[i].mode;
      vji_ir_out = vecs[i].ir_out;
      send(vecs[i].ir, vecs[i].dr, vecs[i].exp_dr, vecs[i].exp_rir, LAT_FULL, 4, 1'b0);
      wait_idle();
    end

    // Back-to-back: valid stays high; second command must wait for the
    // response cycle and be taken exactly then.
    tdo_mode = 0;
    vji_ir_out = 2'b01;
    send(2'b10, 38'h0A_BCDE_F012, 38'h0A_BCDE_F012, 2'b01, LAT_FULL, 4, 1'b1);
    @(posedge clk); #1;
    bus.cmd_ir = 2'b01;
    bus.cmd_dr = 38'h35_5555_AAAA;
    @(negedge clk);
    chk("busy_ready", bus.cmd_ready, 0);
    wait_ready(ok);
    if (ok) begin
      chk("b2b_same_cycle", bus.rsp_valid, 1);
      push(2'b01, 38'h35_5555_AAAA, 38'h35_5555_AAAA, 2'b01, LAT_FULL, 4);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    wait_idle();

    // Reset asserted around bit 17 of SDR aborts the scan.
    vji_ir_out = 2'b01;
    send(2'b11, 38'h0F_0F0F_0F0F, 38'h0F_0F0F_0F0F, 2'b01, LAT_FULL, 4, 1'b0);
    n = 0;
    while (!vji_sdr && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach_sdr", vji_sdr, 1);
    repeat (17 * 4 + 1) @(negedge clk);
    chk("abort_in_sdr", vji_sdr, 1);
    rsp_before = rsp_cnt;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check_reset_vals("abort");
    sb.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("no_rsp_after_abort", rsp_cnt - rsp_before, 0);

    vji_ir_out = 2'b11;
    send(2'b10, 38'h21_4365_8709, 38'h21_4365_8709, 2'b11, LAT_FULL, 4, 1'b0);
    wait_idle();

`ifdef NIOS2_DBG_IR_SKIP_EN
    // Same IR as the previous completed scan: no UIR, rsp_ir keeps 2'b11.
    vji_ir_out = 2'b00;
    send(2'b10, 38'h1C_3C3C_C3C3, 38'h1C_3C3C_C3C3, 2'b11, LAT_SKIP, 0, 1'b0);
    wait_idle();
    chk("rsp_total", rsp_cnt, 9);
`else
    chk("rsp_total", rsp_cnt, 8);
`endif

    chk("invariants", inv_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
